// File: rtl/jtframe_pll_pkg.sv
// Shared definitions for the PLL supervisor: FSM state encoding and the
// saturation limit of the lost-lock counter.
package jtframe_pll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    SETTLE,
    RUN,
    LOST
  } state_t;

  localparam logic [7:0] LOST_MAX = 8'd255;

endpackage

// File: rtl/jtframe_sync.sv
// N-stage synchronizer for a W-bit bus of asynchronous inputs.
// All stages clear to 0 on reset so no stale level survives a reset.
module jtframe_sync #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [N-1:0][W-1:0] stage_q, stage_d;

  // shift the raw input one stage deeper every cycle
  always_comb begin
    stage_d = {stage_q[N-2:0], din};
  end

  // synchronizer register chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign dout = stage_q[N-1];

endmodule

// File: rtl/jtframe_pll_supervisor.sv
// PLL supervisor: holds rst_out high until the PLL has been locked for a
// full settle period, then releases it and watches for lock loss.
// Optional frequency checker (probe edge count per window) is compiled in
// with the macro JTFRAME_PLL_FREQCHK_EN; without it probe is ignored and
// freq_err stays 0.
module jtframe_pll_supervisor
  import jtframe_pll_pkg::*;
#(
  parameter int SYNC_N    = 2,
  parameter int SETTLE_W  = 16,
  parameter int WIN_W     = 10,
  parameter int EXP_EDGES = 213,
  parameter int TOL       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  input  logic       probe,
  output logic       rst_out,
  output logic       lock_ok,
  output logic       freq_err,
  output logic [7:0] lost_cnt
);

  logic                lk_s;
  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [7:0]          lost_q, lost_d;
  logic                rst_out_q, rst_out_d;
  logic                lock_ok_q, lock_ok_d;
  logic                freq_err_q, freq_err_d;
  logic                freq_fault;

  jtframe_sync #(.N(SYNC_N), .W(1)) u_sync_lock (
    .clk  (clk),
    .rst  (rst),
    .din  (locked),
    .dout (lk_s)
  );

`ifdef JTFRAME_PLL_FREQCHK_EN
  localparam logic [WIN_W:0] EDGE_MAX = '1;

  logic             prb_s, prb_prev_q;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W:0]   edge_q, edge_d, edge_inc;
  logic             win_end, in_tol;

  jtframe_sync #(.N(SYNC_N), .W(1)) u_sync_probe (
    .clk  (clk),
    .rst  (rst),
    .din  (probe),
    .dout (prb_s)
  );

  // count probe rising edges over a window; counters idle at 0 outside RUN
  // so every RUN entry starts a fresh window
  always_comb begin
    win_d      = '0;
    edge_d     = '0;
    freq_fault = 1'b0;
    freq_err_d = freq_err_q;
    edge_inc   = edge_q;
    if (prb_s && !prb_prev_q && (edge_q != EDGE_MAX))
      edge_inc = edge_q + (WIN_W+1)'(1);
    win_end = (win_q == '1);
    in_tol  = (int'(edge_inc) >= EXP_EDGES - TOL) &&
              (int'(edge_inc) <= EXP_EDGES + TOL);
    if (state_q == RUN) begin
      win_d  = win_q + WIN_W'(1);
      edge_d = win_end ? '0 : edge_inc;
      if (win_end && !in_tol) begin
        freq_fault = 1'b1;
        freq_err_d = 1'b1;
      end
    end
  end

  // frequency checker registers; prb_prev tracks probe in every state so
  // the first RUN cycle never sees a spurious edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q      <= '0;
      edge_q     <= '0;
      prb_prev_q <= 1'b0;
    end else begin
      win_q      <= win_d;
      edge_q     <= edge_d;
      prb_prev_q <= prb_s;
    end
  end
`else
  logic        unused_probe;
  logic [31:0] unused_cfg;
  assign unused_probe = probe;
  assign unused_cfg   = WIN_W ^ EXP_EDGES ^ TOL;
  assign freq_fault   = 1'b0;
  assign freq_err_d   = 1'b0;
`endif

  // next-state logic; a locked drop in SETTLE wins over the settle wrap
  always_comb begin
    state_d   = state_q;
    settle_d  = '0;
    lost_d    = lost_q;
    rst_out_d = (state_q != RUN);
    lock_ok_d = (state_q == RUN);
    case (state_q)
      IDLE:      state_d = WAIT_LOCK;
      WAIT_LOCK: if (lk_s) state_d = SETTLE;
      SETTLE: begin
        settle_d = settle_q + SETTLE_W'(1);
        if (!lk_s) begin
          state_d  = WAIT_LOCK;
          settle_d = '0;
        end else if (settle_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: if (!lk_s || freq_fault) state_d = LOST;
      LOST: begin
        state_d = WAIT_LOCK;
        if (lost_q != LOST_MAX) lost_d = lost_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers; rst_out presets asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      lost_q     <= '0;
      rst_out_q  <= 1'b1;
      lock_ok_q  <= 1'b0;
      freq_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      lost_q     <= lost_d;
      rst_out_q  <= rst_out_d;
      lock_ok_q  <= lock_ok_d;
      freq_err_q <= freq_err_d;
    end
  end

  assign rst_out  = rst_out_q;
  assign lock_ok  = lock_ok_q;
  assign freq_err = freq_err_q;
  assign lost_cnt = lost_q;

endmodule

// File: tb/tb_jtframe_pll_supervisor.sv
// Scoreboard bench for jtframe_pll_supervisor. Stimulus predicts each output
// change (cycle and value) from the timing rules and queues it; a monitor
// pops and compares whenever the output tuple changes.
module tb_jtframe_pll_supervisor;

  localparam int SYNC_N    = 2;
  localparam int SETTLE_W  = 4;
  localparam int WIN_W     = 6;
  localparam int EXP_EDGES = 16;
  localparam int TOL       = 1;

  // latencies from a raw input change (at a falling clk edge) to the output change
  localparam int RUN_LAT   = SYNC_N + 1 + (1 << SETTLE_W) + 1;          // 20
  localparam int DROP_LAT  = SYNC_N + 2;                                // 4
  localparam int FAULT_LAT = SYNC_N + 1 + (1 << SETTLE_W) + (1 << WIN_W); // 83
  localparam int RERUN_LAT = FAULT_LAT + 1 + 1 + (1 << SETTLE_W) + 1;   // 102
  localparam logic [10:0] RST_TUPLE = {1'b1, 1'b0, 1'b0, 8'd0};

  typedef struct {
    int          cyc;
    logic [10:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       probe = 1'b0;
  logic       rst_out, lock_ok, freq_err;
  logic [7:0] lost_cnt;

  int  cyc = 0;
  int  per = 4;
  int  checks = 0;
  int  failures = 0;
  int  lost_m = 0;
  logic ferr_m = 1'b0;
  ev_t exp_q[$];

  jtframe_pll_supervisor #(
    .SYNC_N(SYNC_N), .SETTLE_W(SETTLE_W), .WIN_W(WIN_W),
    .EXP_EDGES(EXP_EDGES), .TOL(TOL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .locked   (locked),
    .probe    (probe),
    .rst_out  (rst_out),
    .lock_ok  (lock_ok),
    .freq_err (freq_err),
    .lost_cnt (lost_cnt)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // free-running probe with a programmable period
  initial forever begin
    @(negedge clk);
    probe = ((cyc % per) < (per / 2));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic push_ev(input int c, input logic r, input logic l);
    ev_t e;
    e.cyc = c;
    e.val = {r, l, ferr_m, 8'(lost_m)};
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: %0d events still pending at cyc=%0d, required 0",
               nm, exp_q.size(), cyc);
      exp_q.delete();
    end
  endtask

  // one lock/unlock episode: optional single-cycle glitch g cycles after the
  // rise (restarts the settle period), RUN held for 'hold' cycles, then drop
  task automatic episode(input int g, input int hold);
    int n;
    @(negedge clk);
    locked = 1'b1;
    n = cyc;
    if (g > 0) begin
      repeat (g - 1) @(negedge clk);
      locked = 1'b0;
      @(negedge clk);
      locked = 1'b1;
      n = cyc;
    end
    push_ev(n + RUN_LAT, 1'b0, 1'b1);
    wait_drain(RUN_LAT + 8, "run_entry");
    repeat (hold) @(negedge clk);
    locked = 1'b0;
    n = cyc;
    lost_m = (lost_m < 255) ? lost_m + 1 : 255;
    push_ev(n + DROP_LAT, 1'b1, 1'b0);
    wait_drain(DROP_LAT + 8, "run_exit");
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // monitor: every change of the output tuple must match the queue head
  initial begin
    logic [10:0] prev, cur;
    ev_t e;
    prev = RST_TUPLE;
    forever begin
      @(negedge clk);
      cur = {rst_out, lock_ok, freq_err, lost_cnt};
      if (rst) begin
        prev = RST_TUPLE;
      end else if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got=%h required no change from %h",
                   cyc, cur, prev);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.val !== cur) begin
            failures++;
            $display("FAIL output_event got cyc=%0d val=%h required cyc=%0d val=%h",
                     cyc, cur, e.cyc, e.val);
          end else begin
            $display("event cyc=%0d rst_out=%b lock_ok=%b freq_err=%b lost_cnt=%0d ok",
                     cyc, cur[10], cur[9], cur[8], cur[7:0]);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    logic [10:0] t;
    int n;

    // reset state
    repeat (3) @(negedge clk);
    checks++;
    t = {rst_out, lock_ok, freq_err, lost_cnt};
    if (t !== RST_TUPLE) begin
      failures++;
      $display("FAIL reset_state got=%h required=%h", t, RST_TUPLE);
    end
    rst = 1'b0;

    // first lock 10 cycles after reset release, then glitched settles
    repeat (9) @(negedge clk);
    episode(0, 5);
    episode(9, 3);
    episode(17, 0);     // glitch seen on the settle-wrap cycle
    for (int i = 0; i < 300; i++)
      episode(($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 17)) : 0,
              $urandom_range(0, 15));

    checks++;
    if (lost_cnt !== 8'd255) begin
      failures++;
      $display("FAIL lost_saturate got=%0d required=255", lost_cnt);
    end

    // in-tolerance probe: long RUN, no fault
    per = 4;
    repeat (8) @(negedge clk);
    @(negedge clk);
    locked = 1'b1;
    n = cyc;
    push_ev(n + RUN_LAT, 1'b0, 1'b1);
    wait_drain(RUN_LAT + 8, "good_probe_entry");
    repeat (200) @(negedge clk);
    checks++;
    if (lock_ok !== 1'b1 || freq_err !== 1'b0) begin
      failures++;
      $display("FAIL good_probe_stay got lock_ok=%b freq_err=%b required 1 0", lock_ok, freq_err);
    end
    locked = 1'b0;
    n = cyc;
    push_ev(n + DROP_LAT, 1'b1, 1'b0);
    wait_drain(DROP_LAT + 8, "good_probe_exit");

    // out-of-tolerance probe: fault at first window end, then re-run
    per = 5;
    repeat (8) @(negedge clk);
    @(negedge clk);
    locked = 1'b1;
    n = cyc;
    push_ev(n + RUN_LAT, 1'b0, 1'b1);
`ifdef JTFRAME_PLL_FREQCHK_EN
    ferr_m = 1'b1;
    push_ev(n + FAULT_LAT, 1'b0, 1'b1);
    push_ev(n + FAULT_LAT + 1, 1'b1, 1'b0);
    push_ev(n + RERUN_LAT, 1'b0, 1'b1);
`endif
    wait_drain(RERUN_LAT + 10, "bad_probe");

    // asynchronous reset mid-window: outputs return without a clk edge
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    t = {rst_out, lock_ok, freq_err, lost_cnt};
    if (t !== RST_TUPLE) begin
      failures++;
      $display("FAIL async_reset got=%h required=%h", t, RST_TUPLE);
    end
    exp_q.delete();
    lost_m = 0;
    ferr_m = 1'b0;
    per = 4;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = cyc;
    push_ev(n + RUN_LAT, 1'b0, 1'b1);   // locked still high: fresh settle
    wait_drain(RUN_LAT + 8, "post_reset_run");
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
